boundary_scan_chain: RTL and testbench
======================================

# boundary_scan_chain

Parametrised multi-bit boundary-scan register: a WIDTH-cell capture/shift/update chain with a separate update (hold) register. Controllable cells keep their driven values stable while new data shifts, and observe-only cells are selected per bit. A one-bit bypass path and a shift counter are included. It sits between core logic and pads, is chained serially through `sin`/`sout`, and generalises the single-bit input/output scan cells to a full register with update staging.

## Interface
Parameters:
- `WIDTH`, 8: number of scan cells (≥1).
- `CTRL_MASK`, all-ones (WIDTH bits): bit i = 1 makes cell i controllable (drives `data_out[i]` in test mode); 0 makes it observe-only.
- `UPD_RESET`, 0 (WIDTH bits): reset value of the update register.

Ports:
- `clock`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `data_in`  input  WIDTH  functional/pad-side values entering the cells.
- `data_out`  output  WIDTH  values leaving the cells.
- `testing`  input  1  1 = test mode (controllable cells drive from the update register).
- `capture`  input  1  load shift register from `data_in`.
- `shift`  input  1  shift one bit toward `sout`.
- `update`  input  1  copy shift register into the update register.
- `bypass`  input  1  route `sin`→`sout` through the 1-bit bypass flop.
- `sin`  input  1  serial scan in.
- `sout`  output  1  serial scan out.
- `full_shift`  output  1  high when exactly WIDTH shifts have occurred since the last capture.

## Operation
- State: `shreg[WIDTH-1:0]`, `upd[WIDTH-1:0]`, `byp` (1 bit), `cnt` (0..WIDTH, saturating).
- Output mux (combinational): `data_out[i] = (testing & CTRL_MASK[i]) ? upd[i] : data_in[i]`.
- `sout = bypass ? byp : shreg[0]`. It is combinational from registers only and never from `sin`.
- Shift (`shift`=1): when `bypass`=0, `shreg <= {sin, shreg[WIDTH-1:1]}`, so the LSB exits first and `sin` enters at the MSB. When `bypass`=1, `byp <= sin` and `shreg` holds. `cnt <= min(cnt+1, WIDTH)` only when `bypass`=0.
- Capture (`capture`=1, `shift`=0): `shreg <= data_in` (pad-side value, not the muxed output), `byp <= 0`, `cnt <= 0`.
- Update (`update`=1, `shift`=0): `upd <= shreg`, using the pre-edge `shreg`.
- Priority and simultaneous events:
  - `shift` overrides both `capture` and `update`; those are ignored in that cycle.
  - `capture` and `update` together: `upd` takes the old `shreg`, and `shreg` takes `data_in`.
- `full_shift = (cnt == WIDTH)`. It stays high under further shifts (saturation) until the next capture or reset.
- `upd` changes only on update or reset. Controllable outputs therefore stay glitch-free while shifting.

## Timing
- Reset (asynchronous, `reset`=0): `shreg`=0, `upd`=`UPD_RESET`, `byp`=0, `cnt`=0.
- Values while held in reset:
  - `sout`=0 (either `bypass` value).
  - `full_shift`=0.
  - `data_out` per the mux, using `upd`=`UPD_RESET`.
- Reset release takes effect at the next rising edge; there is no additional latency.
- Latency, with `bypass`=0: `sin` at edge k appears on `sout` after edge k+WIDTH-1 (WIDTH-stage path).
- Latency, with `bypass`=1: `sin` appears on `sout` after one edge.
- Capture→`sout`: `data_in[0]` is visible on `sout` the cycle after the capture edge.
- Update→`data_out`: new value visible the cycle after the update edge (if `testing`=1).
- `testing` and `bypass` are combinational selects with no registered latency.
- Reset mid-shift aborts the sequence; the chain returns to reset values immediately.

## Test plan
- Reset: assert `reset`=0 with random inputs -> `sout`=0, `full_shift`=0, `upd`=0. With `testing`=1 and `CTRL_MASK`=all-ones, `data_out`=8'h00.
- Capture/shift-out (WIDTH=8): `data_in`=8'hA5, pulse `capture`, then 8 shift cycles -> `sout` sequence 1,0,1,0,0,1,0,1. `full_shift` rises after the 8th shift and stays high on a 9th.
- Shift-in/update/drive: shift in 8'h3C (LSB first), pulse `update`, `testing`=1 -> `data_out`=8'h3C. During the next 8 shifts of 8'hFF, `data_out` stays 8'h3C.
- Observe-only mask: `CTRL_MASK`=8'h0F, `upd`=8'hFF, `data_in`=8'h00, `testing`=1 -> `data_out`=8'h0F.
- Bypass: `bypass`=1, `sin` pattern 1,1,0 -> `sout` 1,1,0 delayed one cycle, `shreg` unchanged. A capture then resets `byp` to 0.
- Simultaneous and priority:
  - `shift`+`update` -> `upd` unchanged.
  - `capture`+`update` with `shreg`=8'h55, `data_in`=8'hAA -> `upd`=8'h55, `shreg`=8'hAA.
  - Async reset mid-shift -> immediate reset values.

Source files
------------

// File: rtl/boundary_scan_chain.sv
// WIDTH-cell boundary-scan register: capture/shift chain, staged update register,
// per-cell observe-only masking, one-bit bypass flop and a saturating shift counter.
module boundary_scan_chain #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] CTRL_MASK = '1,
    parameter logic [WIDTH-1:0] UPD_RESET = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    input  logic             testing,
    input  logic             capture,
    input  logic             shift,
    input  logic             update,
    input  logic             bypass,
    input  logic             sin,
    output logic             sout,
    output logic             full_shift
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] upd;
    logic             byp;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg_shifted;

    // sin enters at the MSB so the LSB leaves the chain first
    generate
        if (WIDTH == 1) begin : g_single
            assign shreg_shifted = sin;
        end else begin : g_multi
            assign shreg_shifted = {sin, shreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            upd   <= UPD_RESET;
            byp   <= 1'b0;
            cnt   <= '0;
        end else if (shift) begin
            if (bypass) begin
                byp <= sin;
            end else begin
                shreg <= shreg_shifted;
                if (cnt != CW'(WIDTH))
                    cnt <= cnt + 1'b1;
            end
        end else begin
            // update samples the pre-edge shreg even when capture reloads it
            if (capture) begin
                shreg <= data_in;
                byp   <= 1'b0;
                cnt   <= '0;
            end
            if (update)
                upd <= shreg;
        end
    end

    assign data_out   = testing ? ((upd & CTRL_MASK) | (data_in & ~CTRL_MASK)) : data_in;
    assign sout       = bypass ? byp : shreg[0];
    assign full_shift = (cnt == CW'(WIDTH));

endmodule

// File: tb/tb_boundary_scan_chain.sv
// Bench for boundary_scan_chain: directed scenarios plus randomized traffic against
// a queue-based reference model; a second instance exercises an observe-only mask.
module tb_boundary_scan_chain;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         testing, capture, shift, update, bypass, sin;
    logic [W-1:0] data_out, data_out_m;
    logic         sout, sout_m, full_shift, full_shift_m;

    int checks = 0;
    int errors = 0;

    // reference model: chain as a bit queue, element 0 is the cell nearest sout
    int           q[$];
    logic [W-1:0] upd_m;
    logic         byp_m;
    int           cnt_m;

    always #5 clock = ~clock;

    boundary_scan_chain #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .data_out(data_out),
        .testing(testing), .capture(capture), .shift(shift), .update(update),
        .bypass(bypass), .sin(sin), .sout(sout), .full_shift(full_shift)
    );

    boundary_scan_chain #(.WIDTH(W), .CTRL_MASK(8'h0F), .UPD_RESET(8'h00)) dutm (
        .clock(clock), .reset(reset), .data_in(data_in), .data_out(data_out_m),
        .testing(testing), .capture(capture), .shift(shift), .update(update),
        .bypass(bypass), .sin(sin), .sout(sout_m), .full_shift(full_shift_m)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_q();
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i++) v[i] = q[i][0];
        return v;
    endfunction

    function automatic logic [W-1:0] exp_dout(input logic [W-1:0] mask);
        return testing ? ((upd_m & mask) | (data_in & ~mask)) : data_in;
    endfunction

    task automatic model_reset();
        q = {};
        repeat (W) q.push_back(0);
        upd_m = '0;
        byp_m = 1'b0;
        cnt_m = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] old;
        if (shift) begin
            if (bypass) begin
                byp_m = sin;
            end else begin
                void'(q.pop_front());
                q.push_back(int'(sin));
                if (cnt_m < W) cnt_m++;
            end
        end else begin
            old = pack_q();
            if (capture) begin
                q = {};
                for (int i = 0; i < W; i++) q.push_back(int'(data_in[i]));
                byp_m = 1'b0;
                cnt_m = 0;
            end
            if (update) upd_m = old;
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_sout;
        exp_sout = bypass ? byp_m : q[0][0];
        check({tag, ".data_out"}, data_out, exp_dout(8'hFF));
        check({tag, ".data_out_mask"}, data_out_m, exp_dout(8'h0F));
        check({tag, ".sout"}, sout, exp_sout);
        check({tag, ".sout_mask"}, sout_m, exp_sout);
        check({tag, ".full_shift"}, full_shift, (cnt_m == W));
        check({tag, ".full_shift_mask"}, full_shift_m, (cnt_m == W));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        capture = 1'b0; shift = 1'b0; update = 1'b0; bypass = 1'b0; sin = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        check({tag, ".sout0"}, sout, 1'b0);
        check({tag, ".full0"}, full_shift, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        logic [W-1:0] pat;
        logic [2:0]   bpat;

        // reset held with random inputs
        reset   = 1'b0;
        data_in = W'($urandom);
        testing = 1'b1;
        capture = 1'($urandom); shift = 1'($urandom); update = 1'($urandom);
        bypass  = 1'b0; sin = 1'($urandom);
        model_reset();
        #2;
        check_all("reset_b0");
        check("reset_dout", data_out, 8'h00);
        check("reset_sout_b0", sout, 1'b0);
        bypass = 1'b1;
        #1;
        check_all("reset_b1");
        check("reset_sout_b1", sout, 1'b0);
        check("reset_full", full_shift, 1'b0);
        @(negedge clock);
        idle();
        reset = 1'b1;

        // capture A5 and shift it out, LSB first
        pat = 8'hA5;
        data_in = pat; capture = 1'b1;
        step("capture");
        capture = 1'b0;
        for (int k = 0; k < W; k++) begin
            check("cap_sout_seq", sout, pat[k]);
            check("full_before_8", full_shift, 1'b0);
            shift = 1'b1; sin = 1'($urandom);
            step("shift_out");
        end
        check("full_after_8", full_shift, 1'b1);
        step("shift_9th");
        check("full_after_9", full_shift, 1'b1);

        // shift in 3C, update, then shift FF while outputs hold
        pat = 8'h3C;
        for (int k = 0; k < W; k++) begin
            sin = pat[k];
            step("shift_in");
        end
        shift = 1'b0; update = 1'b1; testing = 1'b1; data_in = W'($urandom);
        step("update_3c");
        update = 1'b0;
        check("drive_3c", data_out, 8'h3C);
        for (int k = 0; k < W; k++) begin
            shift = 1'b1; sin = 1'b1; data_in = W'($urandom);
            step("hold_while_shift");
            check("hold_3c", data_out, 8'h3C);
        end

        // observe-only mask: upd=FF, data_in=00
        shift = 1'b0; update = 1'b1;
        step("update_ff");
        update = 1'b0; data_in = 8'h00;
        #1;
        check("mask_0f", data_out_m, 8'h0F);
        check("mask_full", data_out, 8'hFF);

        // bypass: sin 1,1,0 appears one edge later, chain untouched
        bypass = 1'b1; shift = 1'b1;
        bpat = 3'b011;
        for (int k = 0; k < 3; k++) begin
            sin = bpat[k];
            step("bypass");
            check("bypass_sout", sout, bpat[k]);
        end
        sin = 1'b1;
        step("bypass_last");
        bypass = 1'b0; shift = 1'b0; update = 1'b1; data_in = 8'h5A;
        step("bypass_shreg_kept");
        update = 1'b0;
        check("bypass_shreg_ff", data_out, 8'hFF);
        capture = 1'b1;
        step("capture_clears_byp");
        capture = 1'b0; bypass = 1'b1;
        #1;
        check("byp_cleared", sout, 1'b0);
        bypass = 1'b0;

        // shift+update: update ignored
        data_in = 8'h55; capture = 1'b1;
        step("cap55");
        capture = 1'b0; shift = 1'b1; update = 1'b1; sin = 1'b0;
        step("shift_update");
        check("shift_update_upd", data_out, 8'hFF);
        shift = 1'b0; update = 1'b0; capture = 1'b1;
        step("recap55");

        // capture+update together
        data_in = 8'hAA; capture = 1'b1; update = 1'b1;
        step("cap_upd");
        capture = 1'b0; update = 1'b0;
        check("cap_upd_upd", data_out, 8'h55);
        check("cap_upd_sout", sout, 1'b0);
        update = 1'b1;
        step("cap_upd_shreg");
        update = 1'b0;
        check("cap_upd_shreg_aa", data_out, 8'hAA);

        // async reset mid-shift
        shift = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sin = 1'($urandom);
            step("pre_reset_shift");
        end
        async_reset("reset_mid_shift");
        check("reset_mid_dout", data_out, 8'h00);
        step("post_reset_shift");

        // randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 400; n++) begin
            data_in = W'($urandom);
            testing = 1'($urandom);
            shift   = ($urandom_range(0, 2) != 0);
            capture = ($urandom_range(0, 5) == 0);
            update  = ($urandom_range(0, 5) == 0);
            bypass  = ($urandom_range(0, 4) == 0);
            sin     = 1'($urandom);
            step("random");
            if ($urandom_range(0, 59) == 0) async_reset("random_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
